timer_sequencer: RTL and testbench

- Avalon-MM master that owns the 16-bit-interface interval timer slave: programs its 32-bit period, starts and stops it, services its IRQ, and reads its counter snapshot.
- Sits between host-side control logic and the timer's s1 slave port.
- Host logic requests operations through simple pulse/level signals, so no CPU access to the timer is needed.
- Single master on the timer port; it arbitrates its own internal requests.

---
 rtl/timer_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_timer_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_sequencer.sv
// Avalon-MM master that programs, starts, stops and services the interval timer from pulse requests.
// Optional macro TIMER_SEQ_SNAP_EN adds the snap_req path (addr 4/5 snapshot reads).
module timer_sequencer #(
  parameter int TICK_CNT_W = 16,
  parameter int CTRL_ITO   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_start,
  input  logic [31:0]           cfg_period,
  input  logic                  cfg_continuous,
  input  logic                  stop_req,
  input  logic                  snap_req,
  output logic                  busy,
  output logic                  done,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  tick_ovf,
  output logic [31:0]           snap_value,
  output logic                  snap_valid,
  input  logic                  tmr_irq,
  output logic [2:0]            tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [15:0]           tmr_writedata,
  input  logic [15:0]           tmr_readdata
);

  typedef enum logic [3:0] {
    IDLE, CFG_PL, CFG_PH, CFG_CTL, STOP, CLR, CLR_WAIT
`ifdef TIMER_SEQ_SNAP_EN
    , SNAP_W, SNAP_RL, SNAP_RH, SNAP_DONE
`endif
  } state_t;

  localparam logic ITO_BIT = CTRL_ITO[0];

  state_t      state, state_nxt;
  logic        pend_cfg, pend_stop;
  logic [31:0] period_q;
  logic        cont_q;
  logic        in_idle;
  logic        stop_any, cfg_any;
  logic        acc_irq, acc_stop, acc_cfg;

  assign in_idle  = (state == IDLE);
  assign busy     = !in_idle;
  assign stop_any = pend_stop | stop_req;
  assign cfg_any  = pend_cfg | cfg_start;

  // Fixed priority: irq > stop > cfg > snap; irq is level, so it needs no pending flag
  assign acc_irq  = in_idle & tmr_irq;
  assign acc_stop = in_idle & ~tmr_irq & stop_any;
  assign acc_cfg  = in_idle & ~tmr_irq & ~stop_any & cfg_any;

`ifdef TIMER_SEQ_SNAP_EN
  logic        pend_snap, snap_any, acc_snap;
  logic [15:0] snap_lo;
  logic [31:0] snap_value_q;

  assign snap_any = pend_snap | snap_req;
  assign acc_snap = in_idle & ~tmr_irq & ~stop_any & ~cfg_any & snap_any;
  // High half arrives in SNAP_DONE, so present it directly alongside snap_valid
  assign snap_value = (state == SNAP_DONE) ? {tmr_readdata, snap_lo} : snap_value_q;
`else
  logic unused_snap;
  assign unused_snap = ^{snap_req, tmr_readdata};
  assign snap_value  = 32'h0;
  assign snap_valid  = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'h0;
    done           = 1'b0;
    tick           = 1'b0;
`ifdef TIMER_SEQ_SNAP_EN
    snap_valid     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (acc_irq)       state_nxt = CLR;
        else if (acc_stop) state_nxt = STOP;
        else if (acc_cfg)  state_nxt = CFG_PL;
`ifdef TIMER_SEQ_SNAP_EN
        else if (acc_snap) state_nxt = SNAP_W;
`endif
      end
      CFG_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd2;
        tmr_writedata  = period_q[15:0];
        state_nxt      = CFG_PH;
      end
      CFG_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd3;
        tmr_writedata  = period_q[31:16];
        state_nxt      = CFG_CTL;
      end
      CFG_CTL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd1;
        tmr_writedata  = {12'b0, 1'b0, 1'b1, cont_q, ITO_BIT};
        done           = 1'b1;
        state_nxt      = IDLE;
      end
      STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd1;
        tmr_writedata  = 16'h0008;
        done           = 1'b1;
        state_nxt      = IDLE;
      end
      CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd0;
        tick           = 1'b1;
        state_nxt      = CLR_WAIT;
      end
      // The slave still asserts irq here; it drops one cycle after the clear
      CLR_WAIT: state_nxt = IDLE;
`ifdef TIMER_SEQ_SNAP_EN
      SNAP_W: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd4;
        state_nxt      = SNAP_RL;
      end
      SNAP_RL: begin
        tmr_chipselect = 1'b1;
        tmr_address    = 3'd4;
        state_nxt      = SNAP_RH;
      end
      SNAP_RH: begin
        tmr_chipselect = 1'b1;
        tmr_address    = 3'd5;
        state_nxt      = SNAP_DONE;
      end
      SNAP_DONE: begin
        snap_valid     = 1'b1;
        done           = 1'b1;
        state_nxt      = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      pend_cfg   <= 1'b0;
      pend_stop  <= 1'b0;
      period_q   <= 32'h0;
      cont_q     <= 1'b0;
      tick_count <= '0;
      tick_ovf   <= 1'b0;
    end else begin
      state     <= state_nxt;
      pend_stop <= stop_any & ~acc_stop;
      pend_cfg  <= cfg_any & ~acc_cfg;
      if (acc_cfg) begin
        period_q <= cfg_period;
        cont_q   <= cfg_continuous;
        tick_ovf <= 1'b0;
      end
      if (state == CLR) begin
        tick_count <= tick_count + TICK_CNT_W'(1);
        if (&tick_count) tick_ovf <= 1'b1;
      end
    end
  end

`ifdef TIMER_SEQ_SNAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_snap    <= 1'b0;
      snap_lo      <= 16'h0;
      snap_value_q <= 32'h0;
    end else begin
      pend_snap <= snap_any & ~acc_snap;
      if (state == SNAP_RH)   snap_lo      <= tmr_readdata;
      if (state == SNAP_DONE) snap_value_q <= {tmr_readdata, snap_lo};
    end
  end
`endif

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: transaction-level model plus directed vectors against a timer slave model.
module tb_timer_sequencer;
  localparam int TW = 8;
  localparam logic [15:0] RD4 = 16'h1234;
  localparam logic [15:0] RD5 = 16'h0005;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          cfg_start = 1'b0, cfg_continuous = 1'b0, stop_req = 1'b0, snap_req = 1'b0;
  logic [31:0]   cfg_period = 32'h0;
  logic          busy, done, tick, tick_ovf, snap_valid;
  logic [TW-1:0] tick_count;
  logic [31:0]   snap_value;
  logic          tmr_irq = 1'b0;
  logic [2:0]    tmr_address;
  logic          tmr_chipselect, tmr_write_n;
  logic [15:0]   tmr_writedata;
  logic [15:0]   tmr_readdata = 16'h0;
  logic          irq_raise = 1'b0, clr_seen = 1'b0;

  int checks = 0, errors = 0, cyc = 0;

  timer_sequencer #(.TICK_CNT_W(TW), .CTRL_ITO(1)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_period(cfg_period),
    .cfg_continuous(cfg_continuous), .stop_req(stop_req), .snap_req(snap_req),
    .busy(busy), .done(done), .tick(tick), .tick_count(tick_count), .tick_ovf(tick_ovf),
    .snap_value(snap_value), .snap_valid(snap_valid), .tmr_irq(tmr_irq),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer slave: registered reads; irq drops one cycle after the clear write
  always @(posedge clk) begin
    if (tmr_chipselect && tmr_write_n)
      tmr_readdata <= (tmr_address == 3'd4) ? RD4 : (tmr_address == 3'd5) ? RD5 : 16'hDEAD;
    clr_seen <= tmr_chipselect && !tmr_write_n && (tmr_address == 3'd0);
    if (clr_seen)  tmr_irq <= 1'b0;
    if (irq_raise) tmr_irq <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic cs; logic wn; logic [2:0] addr; logic [15:0] wd;
    logic busy; logic done; logic tick; logic sv;
  } rec_t;

  function automatic rec_t mk(input logic cs, input logic wn, input logic [2:0] a,
                              input logic [15:0] d, input logic dn, input logic tk, input logic sv);
    rec_t r;
    r.cs = cs; r.wn = wn; r.addr = a; r.wd = d;
    r.busy = 1'b1; r.done = dn; r.tick = tk; r.sv = sv;
    return r;
  endfunction

  // Model: each accepted operation expands into its list of per-cycle expected outputs
  rec_t          prog[$];
  rec_t          e;
  logic          p_cfg = 0, p_stop = 0, p_snap = 0, clr_ovf, m_ovf = 0;
  logic [TW-1:0] m_cnt = '0;
  logic [31:0]   m_snap = 0, exp_snap;
  logic [18:0]   wlog[$];
  int            done_q[$], tick_q[$];
  int            sv_cnt = 0;

  always @(negedge clk) begin
    clr_ovf = 1'b0;
    e = '0;
    e.wn = 1'b1;
    if (!reset_n) begin
      prog.delete();
      p_cfg = 0; p_stop = 0; p_snap = 0;
      m_cnt = '0; m_ovf = 0; m_snap = 0;
    end else begin
      p_stop |= stop_req;
      p_cfg  |= cfg_start;
`ifdef TIMER_SEQ_SNAP_EN
      p_snap |= snap_req;
`endif
      if (prog.size() == 0) begin
        if (tmr_irq) begin
          prog.push_back(mk(1, 0, 3'd0, 16'h0, 0, 1, 0));
          prog.push_back(mk(0, 1, 3'd0, 16'h0, 0, 0, 0));
        end else if (p_stop) begin
          p_stop = 0;
          prog.push_back(mk(1, 0, 3'd1, 16'h0008, 1, 0, 0));
        end else if (p_cfg) begin
          p_cfg = 0; clr_ovf = 1'b1;
          prog.push_back(mk(1, 0, 3'd2, cfg_period[15:0], 0, 0, 0));
          prog.push_back(mk(1, 0, 3'd3, cfg_period[31:16], 0, 0, 0));
          prog.push_back(mk(1, 0, 3'd1, {13'b0, 1'b1, cfg_continuous, 1'b1}, 1, 0, 0));
        end else if (p_snap) begin
          p_snap = 0;
          prog.push_back(mk(1, 0, 3'd4, 16'h0, 0, 0, 0));
          prog.push_back(mk(1, 1, 3'd4, 16'h0, 0, 0, 0));
          prog.push_back(mk(1, 1, 3'd5, 16'h0, 0, 0, 0));
          prog.push_back(mk(0, 1, 3'd0, 16'h0, 1, 0, 1));
        end
      end else begin
        e = prog.pop_front();
      end
    end
    exp_snap = e.sv ? {RD5, RD4} : m_snap;
    chk("chipselect", tmr_chipselect, e.cs);
    chk("write_n", tmr_write_n, e.wn);
    chk("address", tmr_address, e.addr);
    chk("writedata", tmr_writedata, e.wd);
    chk("busy", busy, e.busy);
    chk("done", done, e.done);
    chk("tick", tick, e.tick);
    chk("snap_valid", snap_valid, e.sv);
    chk("tick_count", tick_count, m_cnt);
    chk("tick_ovf", tick_ovf, m_ovf);
    chk("snap_value", snap_value, exp_snap);
    if (reset_n) begin
      if (e.tick) begin
        if (&m_cnt) m_ovf = 1'b1;
        m_cnt = m_cnt + 1'b1;
      end
      if (clr_ovf) m_ovf = 1'b0;
      m_snap = exp_snap;
    end
    if (tmr_chipselect && !tmr_write_n) wlog.push_back({tmr_address, tmr_writedata});
    if (done) done_q.push_back(cyc);
    if (tick) tick_q.push_back(cyc);
    if (snap_valid) sv_cnt++;
  end

  function automatic logic [18:0] wl(input int i);
    return (wlog.size() > i) ? wlog[i] : 19'h7FFFF;
  endfunction

  function automatic int dq(input int i);
    return (done_q.size() > i) ? done_q[i] : -1000;
  endfunction

  task automatic clear_logs();
    wlog.delete(); done_q.delete(); tick_q.delete(); sv_cnt = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_irq(output int lat);
    int k;
    @(posedge clk); #1;
    irq_raise = 1'b1;
    @(posedge clk); #1;
    irq_raise = 1'b0;
    k = cyc;
    for (int i = 0; i < 8 && tick_q.size() == 0; i++) step(1);
    lat = (tick_q.size() > 0) ? tick_q[0] - k : -1;
    step(3);
    tick_q.delete();
  endtask

  int k, lat;

  initial begin
    #1;
    chk("rst_write_n", tmr_write_n, 1'b1);
    chk("rst_cs", tmr_chipselect, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tick_count", tick_count, 0);
    step(3);
    #1 reset_n = 1'b1;
    step(2);

    // cfg with a period that changes after acceptance
    clear_logs();
    @(posedge clk); #1;
    k = cyc;
    cfg_period = 32'h0001_86A0; cfg_continuous = 1'b1; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_period = 32'hFFFF_FFFF; cfg_continuous = 1'b0;
    step(6);
    chk("cfg_nwrites", wlog.size(), 3);
    chk("cfg_w0", wl(0), {3'd2, 16'h86A0});
    chk("cfg_w1", wl(1), {3'd3, 16'h0001});
    chk("cfg_w2", wl(2), {3'd1, 16'h0007});
    chk("cfg_done_lat", dq(0) - k, 3);

    // single irq service
    clear_logs();
    do_irq(lat);
    chk("irq_lat", lat, 1);
    chk("irq_nwrites", wlog.size(), 1);
    chk("irq_w0", wl(0), {3'd0, 16'h0});
    chk("irq_count", tick_count, 1);

    // irq and cfg_start in the same cycle
    clear_logs();
    @(posedge clk); #1 irq_raise = 1'b1;
    @(posedge clk); #1 irq_raise = 1'b0;
    cfg_start = 1'b1; cfg_period = 32'hCAFE_BEEF; cfg_continuous = 1'b0;
    @(posedge clk); #1 cfg_start = 1'b0;
    step(10);
    chk("ic_nwrites", wlog.size(), 4);
    chk("ic_w0", wl(0), {3'd0, 16'h0});
    chk("ic_w1", wl(1), {3'd2, 16'hBEEF});
    chk("ic_w3", wl(3), {3'd1, 16'h0005});
    chk("ic_count", tick_count, 2);

    // simultaneous stop and cfg: stop first
    clear_logs();
    @(posedge clk); #1;
    stop_req = 1'b1; cfg_start = 1'b1; cfg_period = 32'h0000_0010; cfg_continuous = 1'b1;
    @(posedge clk); #1 stop_req = 1'b0; cfg_start = 1'b0;
    step(8);
    chk("sc_nwrites", wlog.size(), 4);
    chk("sc_w0", wl(0), {3'd1, 16'h0008});
    chk("sc_w1", wl(1), {3'd2, 16'h0010});
    chk("sc_w3", wl(3), {3'd1, 16'h0007});
    chk("sc_ndone", done_q.size(), 2);

    // stop pulses while a cfg is in flight merge into one STOP
    clear_logs();
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_period = 32'h0003_0004; cfg_continuous = 1'b0;
    @(posedge clk); #1 cfg_start = 1'b0; stop_req = 1'b1;
    @(posedge clk); #1 stop_req = 1'b1;
    @(posedge clk); #1 stop_req = 1'b0;
    step(8);
    chk("mg_nwrites", wlog.size(), 4);
    chk("mg_w3", wl(3), {3'd1, 16'h0008});

    // snapshot
    clear_logs();
    @(posedge clk); #1;
    k = cyc; snap_req = 1'b1;
    @(posedge clk); #1 snap_req = 1'b0;
    step(8);
`ifdef TIMER_SEQ_SNAP_EN
    chk("snap_nwrites", wlog.size(), 1);
    chk("snap_w0", wl(0), {3'd4, 16'h0});
    chk("snap_value_lit", snap_value, 32'h0005_1234);
    chk("snap_valid_cnt", sv_cnt, 1);
    chk("snap_done_lat", dq(0) - k, 4);
`else
    chk("nosnap_nwrites", wlog.size(), 0);
    chk("nosnap_valid_cnt", sv_cnt, 0);
    chk("nosnap_value", snap_value, 0);
    chk("nosnap_ndone", done_q.size(), 0);
`endif

    // run tick_count up to all-ones, then wrap
    for (int n = 0; n < 300 && tick_count != 8'hFF; n++) do_irq(lat);
    chk("pre_wrap_count", tick_count, 8'hFF);
    chk("pre_wrap_ovf", tick_ovf, 0);
    do_irq(lat);
    chk("wrap_count", tick_count, 0);
    chk("wrap_ovf", tick_ovf, 1);
    @(posedge clk); #1 cfg_start = 1'b1; cfg_period = 32'h0000_0100;
    @(posedge clk); #1 cfg_start = 1'b0;
    step(6);
    chk("ovf_cleared", tick_ovf, 0);
    chk("count_kept", tick_count, 0);

    // asynchronous reset during CFG_PH
    @(posedge clk); #1 cfg_start = 1'b1; cfg_period = 32'h1111_2222;
    @(posedge clk); #1 cfg_start = 1'b0;
    @(posedge clk); #1;
    chk("ph_address", tmr_address, 3'd3);
    chk("ph_busy", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_cs", tmr_chipselect, 0);
    chk("arst_write_n", tmr_write_n, 1);
    chk("arst_busy", busy, 0);
    step(2);
    #1 reset_n = 1'b1;
    clear_logs();
    step(5);
    chk("post_rst_nwrites", wlog.size(), 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ndone", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
